// File: rtl/quire_pkg.sv
// Shared definitions for the posit16_1 quire window arbiter: posit and quire
// geometry, the beat record exchanged with a quire, and the arbiter states.
package quire_pkg;

  localparam int POSIT_W      = 16;
  localparam int POSIT_ES     = 1;
  localparam int QUIRE_W      = 128;
  localparam int BEAT_FRAC_W  = 12;
  localparam int BEAT_SCALE_W = 6;

  // One decoded posit beat as presented to the quire slave side.
  typedef struct packed {
    logic                    sow;
    logic                    eow;
    logic                    sign;
    logic                    zero;
    logic                    NaR;
    logic [BEAT_FRAC_W-1:0]  fraction;
    logic [BEAT_SCALE_W-1:0] scale;
  } beat_t;

  // IDLE: looking for the next window start. LOCKED: forwarding one window.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/quire_window_arbiter_id_fifo.sv
// Small synchronous FIFO carrying the requester ID of every granted window
// until its end-of-window quire result has been handed downstream.
module id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en;
  logic             rd_en;

  // Flags use one extra pointer bit to tell full from empty.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    wr_en    = push_i & ~full_o;
    rd_en    = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    data_o   = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; storage contents need no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ID storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/quire_window_arbiter.sv
// Shares one quire16_1 accumulator between NUM_REQ posit-decode streams.
// Whole windows (sow..eow) are granted round-robin and forwarded
// combinationally; each window's requester ID rides an ID FIFO so the
// end-of-window quire value can be returned tagged with its owner.
module quire_window_arbiter
  import quire_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int FRACTION_WIDTH = 12,
  parameter int SCALE_WIDTH    = 6,
  parameter int ID_WIDTH       = $clog2(NUM_REQ),
  parameter int ID_FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_rts_i,
  output logic [NUM_REQ-1:0]                req_rtr_o,
  input  logic [NUM_REQ-1:0]                req_sow_i,
  input  logic [NUM_REQ-1:0]                req_eow_i,
  input  logic [NUM_REQ-1:0]                req_sign_i,
  input  logic [NUM_REQ-1:0]                req_zero_i,
  input  logic [NUM_REQ-1:0]                req_NaR_i,
  input  logic [NUM_REQ*FRACTION_WIDTH-1:0] req_fraction_i,
  input  logic [NUM_REQ*SCALE_WIDTH-1:0]    req_scale_i,
  output logic                              q_rts_o,
  output logic                              q_sow_o,
  output logic                              q_eow_o,
  output logic                              q_sign_o,
  output logic                              q_zero_o,
  output logic                              q_NaR_o,
  output logic [FRACTION_WIDTH-1:0]         q_fraction_o,
  output logic [SCALE_WIDTH-1:0]            q_scale_o,
  input  logic                              q_rtr_i,
  input  logic                              q_res_rts_i,
  input  logic                              q_res_eow_i,
  input  logic                              q_res_sow_i,
  input  logic                              q_res_NaR_i,
  input  logic [QUIRE_W-1:0]                q_res_data_i,
  output logic                              q_res_rtr_o,
  output logic                              res_rts_o,
  input  logic                              res_rtr_i,
  output logic [QUIRE_W-1:0]                res_data_o,
  output logic                              res_NaR_o,
  output logic [ID_WIDTH-1:0]               res_id_o,
  output logic                              proto_err_o
);

  arb_state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]       grant_q, grant_d;
  logic [ID_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;

  logic                      locked;
  logic [NUM_REQ-1:0]        eligible;
  logic [NUM_REQ-1:0]        violate;
  logic [2*NUM_REQ-1:0]      elig_dbl;
  logic [NUM_REQ-1:0]        elig_rot;
  logic                      any_elig;
  logic                      pick_found;
  logic [ID_WIDTH-1:0]       rr_pick;
  logic                      drop_hit;
  logic [NUM_REQ-1:0]        drop_vec;

  logic                      sel_rts;
  logic                      sel_sow;
  logic                      sel_eow;
  logic                      sel_sign;
  logic                      sel_zero;
  logic                      sel_NaR;
  logic [FRACTION_WIDTH-1:0] sel_fraction;
  logic [SCALE_WIDTH-1:0]    sel_scale;
  logic                      win_xfer;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [ID_WIDTH-1:0]       fifo_head;

  // The start-of-window flag of a result beat carries no information here.
  logic                      unused_res_sow;
  assign unused_res_sow = q_res_sow_i;

  // (base + off) mod NUM_REQ for operands already below NUM_REQ.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input logic [ID_WIDTH-1:0] off);
    logic [ID_WIDTH:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (ID_WIDTH+1)'(NUM_REQ)) sum = sum - (ID_WIDTH+1)'(NUM_REQ);
    return sum[ID_WIDTH-1:0];
  endfunction

  assign locked = (state_q == LOCKED);

  // Round-robin pick of the next window start and lowest-index stray beat.
  always_comb begin
    eligible   = req_rts_i & req_sow_i;
    violate    = req_rts_i & ~req_sow_i;
    any_elig   = |eligible;
    elig_dbl   = {eligible, eligible};
    elig_rot   = NUM_REQ'(elig_dbl >> rr_ptr_q);
    pick_found = 1'b0;
    rr_pick    = rr_ptr_q;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!pick_found && elig_rot[j]) begin
        pick_found = 1'b1;
        rr_pick    = wrap_add(rr_ptr_q, ID_WIDTH'(j));
      end
    end
    drop_hit = 1'b0;
    drop_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!drop_hit && violate[i]) begin
        drop_hit    = 1'b1;
        drop_vec[i] = 1'b1;
      end
    end
  end

  // Mux the granted requester's beat onto the quire side.
  always_comb begin
    sel_rts      = 1'b0;
    sel_sow      = 1'b0;
    sel_eow      = 1'b0;
    sel_sign     = 1'b0;
    sel_zero     = 1'b0;
    sel_NaR      = 1'b0;
    sel_fraction = '0;
    sel_scale    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_rts      = req_rts_i[i];
        sel_sow      = req_sow_i[i];
        sel_eow      = req_eow_i[i];
        sel_sign     = req_sign_i[i];
        sel_zero     = req_zero_i[i];
        sel_NaR      = req_NaR_i[i];
        sel_fraction = req_fraction_i[i*FRACTION_WIDTH +: FRACTION_WIDTH];
        sel_scale    = req_scale_i[i*SCALE_WIDTH +: SCALE_WIDTH];
      end
    end
    win_xfer = locked & sel_rts & q_rtr_i;
  end

  // Next-state logic: grant a window from IDLE, release it on the eow beat.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    fifo_push = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A full FIFO blocks the grant even if a result pops this cycle.
        if (any_elig && !fifo_full) begin
          grant_d   = rr_pick;
          fifo_push = 1'b1;
          state_d   = LOCKED;
        end
      end
      LOCKED: begin
        if (win_xfer && sel_eow) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_add(grant_q, ID_WIDTH'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Upstream handshake and quire slave side; everything held at 0 in reset.
  always_comb begin
    req_rtr_o    = '0;
    proto_err_o  = 1'b0;
    q_rts_o      = 1'b0;
    q_sow_o      = 1'b0;
    q_eow_o      = 1'b0;
    q_sign_o     = 1'b0;
    q_zero_o     = 1'b0;
    q_NaR_o      = 1'b0;
    q_fraction_o = '0;
    q_scale_o    = '0;
    if (rst_n) begin
      if (locked) begin
        q_rts_o      = sel_rts;
        q_sow_o      = sel_sow;
        q_eow_o      = sel_eow;
        q_sign_o     = sel_sign;
        q_zero_o     = sel_zero;
        q_NaR_o      = sel_NaR;
        q_fraction_o = sel_fraction;
        q_scale_o    = sel_scale;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == ID_WIDTH'(i)) req_rtr_o[i] = q_rtr_i;
        end
      end else if (drop_hit) begin
        // Accept and discard one beat that arrived without a window start.
        req_rtr_o   = drop_vec;
        proto_err_o = 1'b1;
      end
    end
  end

  // Result path: swallow intermediate quire values, tag the final one.
  always_comb begin
    res_rts_o   = 1'b0;
    q_res_rtr_o = 1'b0;
    res_data_o  = '0;
    res_NaR_o   = 1'b0;
    res_id_o    = '0;
    fifo_pop    = 1'b0;
    if (rst_n) begin
      res_data_o = q_res_data_i;
      res_NaR_o  = q_res_NaR_i;
      res_id_o   = fifo_empty ? '0 : fifo_head;
      if (q_res_eow_i) begin
        res_rts_o   = q_res_rts_i & ~fifo_empty;
        q_res_rtr_o = res_rtr_i & ~fifo_empty;
        fifo_pop    = q_res_rts_i & res_rtr_i & ~fifo_empty;
      end else begin
        q_res_rtr_o = 1'b1;
      end
    end
  end

  id_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (grant_d),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
